// File: rtl/usb_tx_pkg.sv
// -----------------------------------------------------------------------------
// usb_tx_pkg
// Shared types and constants for the USB transmit framer: FSM state encoding,
// header/trailer lengths, default sync bytes and the bytewise CRC-8 helper
// (poly 0x07, MSB-first, no reflection, no final XOR).
// No ports.
// -----------------------------------------------------------------------------
package usb_tx_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StHdr0,
      StHdr1,
      StSeq,
      StFlags,
      StPayload,
      StCheck
   } tx_state_t;

   localparam int unsigned HDR_LEN = 4;  // sync0, sync1, seq, flags
   localparam int unsigned TRL_LEN = 1;  // check byte

   localparam logic [7:0] SYNC0_DEFAULT = 8'hA5;
   localparam logic [7:0] SYNC1_DEFAULT = 8'h5A;

   localparam logic [7:0] CRC8_POLY = 8'h07;

   // Advance a CRC-8 register by one whole byte.
   function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/usb_tx_framer_if.sv
// -----------------------------------------------------------------------------
// usb_tx_framer_if
// Groups the two byte streams of the framer: formatter input (valid/ready with
// a start-of-line qualifier) and the FT232H TX write port (valid/full).
//   slave  : the framer's view (consumes fmt_*, produces usb_wr_valid/writedata)
//   master : the environment's view (formatter source and USB sink)
// -----------------------------------------------------------------------------
interface usb_tx_framer_if;

   logic       fmt_valid;
   logic [7:0] fmt_data;
   logic       fmt_sof;
   logic       fmt_ready;

   logic       usb_wr_valid;
   logic [7:0] usb_writedata;
   logic       usb_txfull;

   modport master (
      output fmt_valid, fmt_data, fmt_sof, usb_txfull,
      input  fmt_ready, usb_wr_valid, usb_writedata
   );

   modport slave (
      input  fmt_valid, fmt_data, fmt_sof, usb_txfull,
      output fmt_ready, usb_wr_valid, usb_writedata
   );

endinterface

// File: rtl/usb_tx_fifo.sv
// -----------------------------------------------------------------------------
// usb_tx_fifo
// Synchronous first-word-fall-through FIFO: dout always shows the head entry
// while !empty. Push and pop in the same cycle keep count exact.
// Ports:
//   clk_100M, nrst     clock, async active-low reset
//   push, din          write request and data (ignored when full)
//   pop                remove head entry (ignored when empty)
//   dout               head entry
//   full, empty, count occupancy status
// -----------------------------------------------------------------------------
module usb_tx_fifo #(
   parameter int unsigned WIDTH = 9,
   parameter int unsigned DEPTH = 512
) (
   input  logic                     clk_100M,
   input  logic                     nrst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   assign full    = (count_q == FULL_CNT);
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem_q[rd_ptr_q];
   assign count   = count_q;

   always_ff @(posedge clk_100M) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk_100M or negedge nrst) begin
      if (!nrst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/usb_tx_framer.sv
// -----------------------------------------------------------------------------
// usb_tx_framer
// Buffers formatter bytes in a FIFO and emits fixed-length packets to the
// FT232H TX port: SYNC0, SYNC1, seq, flags, PAYLOAD_LEN payload bytes, check.
// A packet only starts once a full payload is buffered, so it never stalls on
// input. flags[0] is the sof bit of the first payload byte.
// Build option: define USB_TX_CRC_EN to make the check byte a CRC-8 over
// seq, flags and payload; otherwise it is the 8-bit sum of the payload.
// Ports:
//   clk_100M, nrst   clock, async active-low reset
//   tx_enable        allows new packets to start
//   bus (slave)      fmt_valid/fmt_data/fmt_sof/fmt_ready input stream,
//                    usb_wr_valid/usb_writedata/usb_txfull output stream
//   pkt_count        packets fully sent (wraps)
//   overflow         sticky: byte offered while FIFO full
//   ovf_clr          synchronous clear of overflow (a new set wins)
// -----------------------------------------------------------------------------
module usb_tx_framer
   import usb_tx_pkg::*;
#(
   parameter int unsigned PAYLOAD_LEN = 256,
   parameter int unsigned FIFO_DEPTH  = 512,
   parameter logic [7:0]  SYNC0       = SYNC0_DEFAULT,
   parameter logic [7:0]  SYNC1       = SYNC1_DEFAULT
) (
   input  logic                  clk_100M,
   input  logic                  nrst,
   input  logic                  tx_enable,
   usb_tx_framer_if.slave        bus,
   output logic [15:0]           pkt_count,
   output logic                  overflow,
   input  logic                  ovf_clr
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned BW = $clog2(PAYLOAD_LEN);
   localparam logic [BW-1:0] LAST_IDX = BW'(PAYLOAD_LEN - 1);

   tx_state_t       state_q, state_d;
   logic            valid_q, valid_d;
   logic [7:0]      data_q, data_d;
   logic [7:0]      seq_q, seq_d;
   logic [15:0]     pkt_q, pkt_d;
   logic [BW-1:0]   cnt_q, cnt_d;
   logic [7:0]      chk_q, chk_d;
   logic [7:0]      chk_upd;
   logic            ovf_q;
   logic            rdy_q;

   logic            fmt_ready;
   logic            fifo_push, fifo_pop, fifo_pop_ok;
   logic [8:0]      fifo_dout;
   logic            fifo_full, fifo_empty;
   logic [CW-1:0]   fifo_count;
   logic            accept, start_ok;

   // rdy_q holds ready low while in reset and for nothing else.
   assign fmt_ready     = rdy_q && !fifo_full;
   assign bus.fmt_ready = fmt_ready;
   assign fifo_push     = bus.fmt_valid && fmt_ready;
   assign fifo_pop_ok   = fifo_pop && !fifo_empty;

   assign accept   = valid_q && !bus.usb_txfull;
   assign start_ok = tx_enable && (32'(fifo_count) >= PAYLOAD_LEN);

   usb_tx_fifo #(
      .WIDTH (9),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_100M (clk_100M),
      .nrst     (nrst),
      .push     (fifo_push),
      .pop      (fifo_pop_ok),
      .din      ({bus.fmt_sof, bus.fmt_data}),
      .dout     (fifo_dout),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

   // Check accumulator folds in the byte currently being accepted (data_q).
`ifdef USB_TX_CRC_EN
   localparam bit HDR_IN_CHK = 1'b1;
   assign chk_upd = crc8_byte(chk_q, data_q);
`else
   localparam bit HDR_IN_CHK = 1'b0;
   assign chk_upd = chk_q + data_q;
`endif

   // State register
   always_ff @(posedge clk_100M or negedge nrst) begin
      if (!nrst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (start_ok) state_d = StHdr0;
         StHdr0:    if (accept)   state_d = StHdr1;
         StHdr1:    if (accept)   state_d = StSeq;
         StSeq:     if (accept)   state_d = StFlags;
         StFlags:   if (accept)   state_d = StPayload;
         StPayload: if (accept && (cnt_q == LAST_IDX)) state_d = StCheck;
         StCheck:   if (accept)   state_d = StIdle;
         default:                 state_d = StIdle;
      endcase
   end

   // Output / datapath next values. data_q always holds the byte on the bus,
   // so each state loads the byte of the following state on acceptance.
   always_comb begin
      valid_d  = valid_q;
      data_d   = data_q;
      seq_d    = seq_q;
      pkt_d    = pkt_q;
      cnt_d    = cnt_q;
      chk_d    = chk_q;
      fifo_pop = 1'b0;
      unique case (state_q)
         StIdle: begin
            chk_d = '0;
            cnt_d = '0;
            if (start_ok) begin
               valid_d = 1'b1;
               data_d  = SYNC0;
            end
         end
         StHdr0: if (accept) data_d = SYNC1;
         StHdr1: if (accept) data_d = seq_q;
         StSeq: begin
            if (accept) begin
               // Peek at the head without popping: sof of payload[0].
               data_d = {7'b0, fifo_dout[8]};
               if (HDR_IN_CHK) chk_d = chk_upd;
            end
         end
         StFlags: begin
            if (accept) begin
               data_d   = fifo_dout[7:0];
               fifo_pop = 1'b1;
               if (HDR_IN_CHK) chk_d = chk_upd;
            end
         end
         StPayload: begin
            if (accept) begin
               chk_d = chk_upd;
               if (cnt_q == LAST_IDX) begin
                  data_d = chk_upd;
               end else begin
                  cnt_d    = cnt_q + 1'b1;
                  data_d   = fifo_dout[7:0];
                  fifo_pop = 1'b1;
               end
            end
         end
         StCheck: begin
            if (accept) begin
               valid_d = 1'b0;
               data_d  = '0;
               seq_d   = seq_q + 8'd1;
               pkt_d   = pkt_q + 16'd1;
            end
         end
         default: begin
            valid_d = 1'b0;
            data_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk_100M or negedge nrst) begin
      if (!nrst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         seq_q   <= '0;
         pkt_q   <= '0;
         cnt_q   <= '0;
         chk_q   <= '0;
         ovf_q   <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         seq_q   <= seq_d;
         pkt_q   <= pkt_d;
         cnt_q   <= cnt_d;
         chk_q   <= chk_d;
         rdy_q   <= 1'b1;
         if (bus.fmt_valid && !fmt_ready) begin
            ovf_q <= 1'b1;
         end else if (ovf_clr) begin
            ovf_q <= 1'b0;
         end
      end
   end

   assign bus.usb_wr_valid  = valid_q;
   assign bus.usb_writedata = data_q;
   assign pkt_count         = pkt_q;
   assign overflow          = ovf_q;

endmodule

// File: tb/tb_usb_tx_framer.sv
module tb_usb_tx_framer;

   localparam int PL = 256;

   logic clk_100M = 1'b0;
   logic nrst;
   logic tx_enable;
   logic ovf_clr;
   logic [15:0] pkt_count;
   logic overflow;

   usb_tx_framer_if bus ();

   usb_tx_framer dut (
      .clk_100M  (clk_100M),
      .nrst      (nrst),
      .tx_enable (tx_enable),
      .bus       (bus),
      .pkt_count (pkt_count),
      .overflow  (overflow),
      .ovf_clr   (ovf_clr)
   );

   always #5 clk_100M = ~clk_100M;

   int checks = 0;
   int errors = 0;
   int acc_cnt = 0;
   int exp_pkts = 0;
   logic [7:0] exp_seq = 8'h00;
   logic [7:0] exp_q [$];
   bit bp_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk_100M);
         #1;
      end
   endtask

`ifdef USB_TX_CRC_EN
   function automatic logic [7:0] crc_step(input logic [7:0] c, input logic [7:0] d);
      logic [7:0] r = c;
      for (int b = 7; b >= 0; b--) begin
         if (r[7] ^ d[b]) r = {r[6:0], 1'b0} ^ 8'h07;
         else             r = {r[6:0], 1'b0};
      end
      return r;
   endfunction
`endif

   // Scoreboard producer: enqueue the full expected packet for one payload block.
   task automatic expect_block(input logic [7:0] base, input logic [7:0] mul, input logic sof0);
      logic [7:0] flags = {7'b0, sof0};
      logic [7:0] chk = 8'h00;
      logic [7:0] b;
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h5A);
      exp_q.push_back(exp_seq);
      exp_q.push_back(flags);
`ifdef USB_TX_CRC_EN
      chk = crc_step(crc_step(8'h00, exp_seq), flags);
`endif
      for (int i = 0; i < PL; i++) begin
         b = 8'(int'(base) + i * int'(mul));
         exp_q.push_back(b);
`ifdef USB_TX_CRC_EN
         chk = crc_step(chk, b);
`else
         chk = chk + b;
`endif
      end
      exp_q.push_back(chk);
      exp_seq++;
      exp_pkts++;
   endtask

   // All main-thread waits end 1 time unit after a posedge.
   task automatic push_byte(input logic [7:0] d, input logic s);
      int n = 0;
      bus.fmt_data  = d;
      bus.fmt_sof   = s;
      bus.fmt_valid = 1'b1;
      while (!bus.fmt_ready && n < 2000) begin
         cyc(1);
         n++;
      end
      if (!bus.fmt_ready) begin
         checks++;
         errors++;
         $display("FAIL push_timeout: fmt_ready got 0 for %0d cycles, required 1", n);
         bus.fmt_valid = 1'b0;
         return;
      end
      cyc(1);
      bus.fmt_valid = 1'b0;
      bus.fmt_sof   = 1'b0;
   endtask

   task automatic push_block(input logic [7:0] base, input logic [7:0] mul, input logic sof0);
      for (int i = 0; i < PL; i++) begin
         push_byte(8'(int'(base) + i * int'(mul)), sof0 && (i == 0));
      end
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         cyc(1);
         n++;
      end
      check("drain_pending_bytes", exp_q.size(), 0);
      exp_q.delete();
      cyc(3);
      check("pkt_count", {16'h0, pkt_count}, 32'(16'(exp_pkts)));
   endtask

   task automatic idle_watch(input string name, input int n);
      bit saw = 1'b0;
      repeat (n) begin
         cyc(1);
         if (bus.usb_wr_valid) saw = 1'b1;
      end
      check(name, saw, 1'b0);
   endtask

   // USB sink: toggles full when backpressure is on; random during reset.
   initial begin
      bus.usb_txfull = 1'b0;
      forever begin
         @(posedge clk_100M);
         #1;
         if (!nrst)      bus.usb_txfull = 1'($urandom);
         else if (bp_en) bus.usb_txfull = ~bus.usb_txfull;
         else            bus.usb_txfull = 1'b0;
      end
   end

   // Scoreboard consumer: compares each accepted byte, checks hold during full.
   logic       hold_pend = 1'b0;
   logic [7:0] hold_data = 8'h00;
   always @(negedge clk_100M) begin
      if (nrst && bus.usb_wr_valid) begin
         if (hold_pend) check("held_data", bus.usb_writedata, hold_data);
         if (!bus.usb_txfull) begin
            if (exp_q.size() == 0) begin
               check("unexpected_byte", 1'b1, 1'b0);
            end else begin
               check($sformatf("byte_%0d", acc_cnt), bus.usb_writedata, exp_q.pop_front());
            end
            acc_cnt++;
            hold_pend = 1'b0;
         end else begin
            hold_pend = 1'b1;
            hold_data = bus.usb_writedata;
         end
      end else if (nrst && hold_pend) begin
         check("valid_held_while_full", 1'b0, 1'b1);
         hold_pend = 1'b0;
      end
   end

   int acc_start;

   initial begin
      nrst          = 1'b0;
      tx_enable     = 1'b0;
      ovf_clr       = 1'b0;
      bus.fmt_valid = 1'b0;
      bus.fmt_data  = 8'h00;
      bus.fmt_sof   = 1'b0;

      // Reset with random inputs
      repeat (6) begin
         cyc(1);
         bus.fmt_valid = 1'($urandom);
         bus.fmt_data  = 8'($urandom);
         bus.fmt_sof   = 1'($urandom);
         tx_enable     = 1'($urandom);
         ovf_clr       = 1'($urandom);
      end
      check("rst_usb_wr_valid", bus.usb_wr_valid, 1'b0);
      check("rst_usb_writedata", bus.usb_writedata, 8'h00);
      check("rst_pkt_count", pkt_count, 16'h0);
      check("rst_overflow", overflow, 1'b0);
      check("rst_fmt_ready", bus.fmt_ready, 1'b0);
      bus.fmt_valid = 1'b0;
      bus.fmt_sof   = 1'b0;
      tx_enable     = 1'b0;
      ovf_clr       = 1'b0;
      cyc(1);
      nrst = 1'b1;
      cyc(2);
      check("post_rst_fmt_ready", bus.fmt_ready, 1'b1);
      check("post_rst_overflow", overflow, 1'b0);

      // Basic packet
      tx_enable = 1'b1;
      expect_block(8'h00, 8'h01, 1'b1);
      push_block(8'h00, 8'h01, 1'b1);
      drain(2000);

      // Backpressure: same stimulus, full toggling
      bp_en = 1'b1;
      expect_block(8'h00, 8'h01, 1'b1);
      push_block(8'h00, 8'h01, 1'b1);
      drain(3000);
      bp_en = 1'b0;

      // Threshold: 255 buffered bytes never start a packet
      expect_block(8'h10, 8'h03, 1'b0);
      for (int i = 0; i < PL - 1; i++) push_byte(8'(16 + i * 3), 1'b0);
      idle_watch("idle_below_threshold", 50);
      push_byte(8'(16 + (PL - 1) * 3), 1'b0);
      drain(2000);

      // Back-to-back packets
      expect_block(8'h21, 8'h05, 1'b1);
      expect_block(8'h33, 8'h07, 1'b0);
      push_block(8'h21, 8'h05, 1'b1);
      push_block(8'h33, 8'h07, 1'b0);
      drain(3000);

      // Disabled: fill FIFO, overflow, clear, set-wins
      tx_enable = 1'b0;
      expect_block(8'h40, 8'h0B, 1'b1);
      expect_block(8'h55, 8'h0D, 1'b0);
      push_block(8'h40, 8'h0B, 1'b1);
      push_block(8'h55, 8'h0D, 1'b0);
      check("full_fmt_ready", bus.fmt_ready, 1'b0);
      check("disabled_no_valid", bus.usb_wr_valid, 1'b0);
      check("disabled_pkt_count", pkt_count, 16'(exp_pkts - 2));
      check("pre_ovf", overflow, 1'b0);
      bus.fmt_data  = 8'hEE;
      bus.fmt_valid = 1'b1;
      cyc(1);
      bus.fmt_valid = 1'b0;
      check("ovf_set", overflow, 1'b1);
      ovf_clr = 1'b1;
      cyc(1);
      ovf_clr = 1'b0;
      check("ovf_clr", overflow, 1'b0);
      bus.fmt_valid = 1'b1;
      ovf_clr       = 1'b1;
      cyc(1);
      bus.fmt_valid = 1'b0;
      ovf_clr       = 1'b0;
      check("ovf_set_wins", overflow, 1'b1);
      ovf_clr = 1'b1;
      cyc(1);
      ovf_clr = 1'b0;
      check("ovf_clr2", overflow, 1'b0);
      tx_enable = 1'b1;
      drain(3000);

      // Drop tx_enable mid-payload: packet completes, next one waits
      expect_block(8'h07, 8'h11, 1'b1);
      acc_start = acc_cnt;
      push_block(8'h07, 8'h11, 1'b1);
      for (int n = 0; n < 500 && acc_cnt < acc_start + 20; n++) cyc(1);
      tx_enable = 1'b0;
      push_block(8'h99, 8'h13, 1'b0);
      drain(2000);
      idle_watch("idle_after_disable", 50);
      tx_enable = 1'b1;
      expect_block(8'h99, 8'h13, 1'b0);
      drain(2000);

`ifdef USB_TX_CRC_EN
      // Sequence wrap: 256 more packets carry seq past FF
      for (int k = 0; k < 256; k++) begin
         expect_block(8'(k), 8'h01, k[0]);
         push_block(8'(k), 8'h01, k[0]);
      end
      drain(5000);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
